// File: rtl/plot_scheduler_if.sv
// plot_scheduler_if: request/coordinate inputs and pixel/grant outputs of the plot scheduler
interface plot_scheduler_if;
  logic [4:0] req;
  logic [14:0] p1, p2, p3, p4;
  logic [7:0] timer_x;
  logic clear;
  logic [4:0] grant;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic plot;
  logic busy;
  modport master (output req, p1, p2, p3, p4, timer_x, clear, input grant, x, y, colour, plot, busy);
  modport slave (input req, p1, p2, p3, p4, timer_x, clear, output grant, x, y, colour, plot, busy);
endinterface

// File: rtl/plot_scheduler.sv
// plot_scheduler: round-robin pixel arbiter for four players and a timer bar, with a full-screen clear sweep
module plot_scheduler #(
  parameter logic [2:0] CLEAR_COLOUR = 3'b000,
  parameter logic [6:0] TIMER_ROW = 7'd119
) (
  input logic CLOCK_50,
  input logic reset,
  plot_scheduler_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;
  logic [0:0] state;
  logic [2:0] ptr, pick, cand;
  logic [3:0] t;
  logic found;
  logic [4:0] elig;
  logic [7:0] cx;
  logic [6:0] cy;
  logic [2:0] cc;
  assign elig = bus.req & ~bus.grant;
  // first eligible requester at or after ptr, wrapping mod 5
  always_comb begin
    pick = 3'd0;
    found = 1'b0;
    t = 4'd0;
    cand = 3'd0;
    for (int k = 4; k >= 0; k--) begin
      t = {1'b0, ptr} + 4'(k);
      cand = (t >= 4'd5) ? 3'(t - 4'd5) : t[2:0];
      if (elig[cand]) begin
        pick = cand;
        found = 1'b1;
      end
    end
  end
  // coordinates and colour of the selected requester
  always_comb begin
    cx = pick == 3'd0 ? bus.p1[14:7] : pick == 3'd1 ? bus.p2[14:7] : pick == 3'd2 ? bus.p3[14:7] : pick == 3'd3 ? bus.p4[14:7] : bus.timer_x;
    cy = pick == 3'd0 ? bus.p1[6:0] : pick == 3'd1 ? bus.p2[6:0] : pick == 3'd2 ? bus.p3[6:0] : pick == 3'd3 ? bus.p4[6:0] : TIMER_ROW;
    cc = pick == 3'd0 ? 3'b001 : pick == 3'd1 ? 3'b010 : pick == 3'd2 ? 3'b100 : pick == 3'd3 ? 3'b110 : 3'b111;
  end
  // state machine; x/y double as the sweep counters while clearing
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
      ptr <= 3'd0;
      bus.grant <= 5'd0;
      bus.plot <= 1'b0;
      bus.busy <= 1'b0;
      bus.x <= 8'd0;
      bus.y <= 7'd0;
      bus.colour <= 3'd0;
    end else if (state == IDLE) begin
      if (bus.clear) begin
        state <= CLEAR;
        bus.grant <= 5'd0;
        bus.plot <= 1'b1;
        bus.busy <= 1'b1;
        bus.x <= 8'd0;
        bus.y <= 7'd0;
        bus.colour <= CLEAR_COLOUR;
      end else begin
        bus.grant <= found ? 5'b00001 << pick : 5'd0;
        bus.plot <= found && cx <= 8'd159 && cy <= 7'd119;
        bus.busy <= 1'b0;
        if (found) begin
          bus.x <= cx;
          bus.y <= cy;
          bus.colour <= cc;
          ptr <= pick == 3'd4 ? 3'd0 : pick + 3'd1;
        end
      end
    end else if (bus.x == 8'd159 && bus.y == 7'd119) begin
      state <= IDLE;
      bus.plot <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      bus.x <= bus.x == 8'd159 ? 8'd0 : bus.x + 8'd1;
      bus.y <= bus.x == 8'd159 ? bus.y + 7'd1 : bus.y;
    end
  end
endmodule

// File: tb/tb_plot_scheduler.sv
// tb_plot_scheduler: scoreboard bench for plot_scheduler with directed vectors
module tb_plot_scheduler;
  typedef struct {
    logic [24:0] v;
    int gap;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int pass = 0;
  int gap = 0;
  exp_t q[$];
  exp_t e;
  logic [24:0] outs;
  logic act;
  plot_scheduler_if bus();
  plot_scheduler dut (.CLOCK_50(clk), .reset(rst), .bus(bus));
  assign outs = {bus.grant, bus.x, bus.y, bus.colour, bus.plot, bus.busy};
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [24:0] a, input logic [24:0] r);
    total++;
    if (a === r) pass++;
    else $display("FAIL %s: got %h want %h (grant,x,y,colour,plot,busy)", nm, a, r);
  endtask
  task automatic chk_int(input string nm, input int a, input int r);
    total++;
    if (a == r) pass++;
    else $display("FAIL %s: got %0d want %0d", nm, a, r);
  endtask
  task automatic push(input logic [4:0] g, input logic [7:0] px, input logic [6:0] py, input logic [2:0] c, input logic pl, input logic b, input int gp);
    exp_t n;
    n.v = {g, px, py, c, pl, b};
    n.gap = gp;
    q.push_back(n);
  endtask
  task automatic push_sweep(input int n, input int first_gap);
    for (int i = 0; i < n; i++) push(5'd0, 8'(i % 160), 7'(i / 160), 3'b000, 1'b1, 1'b1, i == 0 ? first_gap : 0);
  endtask
  task automatic wait_drain(input int bound);
    int n = 0;
    while (q.size() != 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    chk_int("drain", q.size(), 0);
    repeat (5) @(posedge clk);
  endtask
  always @(negedge clk) begin
    act = (bus.grant != 5'd0) === 1'b1 || bus.plot === 1'b1 || bus.busy === 1'b1;
    if (act) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected: got %h want nothing", outs);
      end else begin
        e = q.pop_front();
        chk("event", outs, e.v);
        if (e.gap >= 0) chk_int("gap", gap, e.gap);
      end
      gap = 0;
    end else gap++;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    rst = 1'b1;
    bus.req = 5'd0;
    bus.clear = 1'b0;
    bus.p1 = {8'd10, 7'd20};
    bus.p2 = {8'd30, 7'd40};
    bus.p3 = {8'd50, 7'd60};
    bus.p4 = {8'd70, 7'd80};
    bus.timer_x = 8'd90;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset", outs, 25'd0);
    bus.req = 5'b11111;
    push(5'b00001, 8'd10, 7'd20, 3'b001, 1'b1, 1'b0, -1);
    push(5'b00010, 8'd30, 7'd40, 3'b010, 1'b1, 1'b0, 0);
    push(5'b00100, 8'd50, 7'd60, 3'b100, 1'b1, 1'b0, 0);
    push(5'b01000, 8'd70, 7'd80, 3'b110, 1'b1, 1'b0, 0);
    push(5'b10000, 8'd90, 7'd119, 3'b111, 1'b1, 1'b0, 0);
    push(5'b00001, 8'd10, 7'd20, 3'b001, 1'b1, 1'b0, 0);
    repeat (6) @(posedge clk);
    #1 bus.req = 5'd0;
    wait_drain(20);
    #1 bus.timer_x = 8'd42;
    bus.req = 5'b10000;
    push(5'b10000, 8'd42, 7'd119, 3'b111, 1'b1, 1'b0, -1);
    push(5'b10000, 8'd42, 7'd119, 3'b111, 1'b1, 1'b0, 1);
    push(5'b10000, 8'd42, 7'd119, 3'b111, 1'b1, 1'b0, 1);
    repeat (5) @(posedge clk);
    #1 bus.req = 5'd0;
    wait_drain(20);
    #1 bus.p3 = {8'd200, 7'd5};
    bus.req = 5'b00100;
    push(5'b00100, 8'd200, 7'd5, 3'b100, 1'b0, 1'b0, -1);
    @(posedge clk);
    #1 bus.req = 5'd0;
    wait_drain(20);
    #1 bus.p3 = {8'd50, 7'd60};
    bus.req = 5'b00001;
    bus.clear = 1'b1;
    push_sweep(19200, -1);
    push(5'b00001, 8'd10, 7'd20, 3'b001, 1'b1, 1'b0, 1);
    @(posedge clk);
    #1 bus.clear = 1'b0;
    n = 0;
    while (bus.grant !== 5'b00001 && n < 25000) begin
      @(posedge clk);
      #1 n++;
    end
    bus.req = 5'd0;
    wait_drain(10);
    #1 bus.clear = 1'b1;
    push_sweep(500, -1);
    @(posedge clk);
    #1 bus.clear = 1'b0;
    repeat (499) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort", {23'd0, bus.plot, bus.busy}, 25'd0);
    chk_int("abort_queue", q.size(), 0);
    repeat (3) @(posedge clk);
    #1 bus.clear = 1'b1;
    push_sweep(19200, -1);
    @(posedge clk);
    #1 bus.clear = 1'b0;
    repeat (999) @(posedge clk);
    #1 bus.clear = 1'b1;
    @(posedge clk);
    #1 bus.clear = 1'b0;
    wait_drain(20000);
    repeat (10) @(posedge clk);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
